// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Purpose  : Shared constants, FSM state type and helpers for the CNN MAC
//             datapath (multiplier tap selects, default widths).
//  Revision : 1.0  initial release
// ============================================================================
package cnn_pkg;

    // Default datapath widths
    localparam int DEF_DATA_W = 8;
    localparam int DEF_PROD_W = 16;
    localparam int DEF_ACC_W  = 20;

    // Tap select encoding on the shared multiplier mux
    localparam logic [1:0] SEL_IDLE = 2'b00;
    localparam logic [1:0] SEL_TAP0 = 2'b01;
    localparam logic [1:0] SEL_TAP1 = 2'b10;
    localparam logic [1:0] SEL_TAP2 = 2'b11;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    // Map an issue-slot index (0..2) to the multiplier tap select
    function automatic logic [1:0] tap_sel(input logic [1:0] idx);
        case (idx)
            2'd0:    return SEL_TAP0;
            2'd1:    return SEL_TAP1;
            default: return SEL_TAP2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_acc.sv
`default_nettype none
// ============================================================================
//  Module   : sat_acc
//  Purpose  : Unsigned saturating accumulator with add-enable, synchronous
//             clear and a sticky saturation flag.
//  Revision : 1.0  initial release
// ============================================================================
module sat_acc
    import cnn_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    input  logic              i_add_en,
    input  logic [PROD_W-1:0] i_addend,
    output logic [ACC_W-1:0]  o_acc,
    output logic              o_sat
);

    localparam logic [ACC_W-1:0] c_ACC_MAX = {ACC_W{1'b1}};

    logic [ACC_W-1:0] r_acc;
    logic             r_sat;
    logic [ACC_W:0]   w_sum;

    // One extra bit so the carry-out flags overflow; once at the maximum any
    // non-zero addend carries again, so the sum pins there until cleared.
    assign w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, i_addend};

    // Accumulate tagged products, saturating on carry-out
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_add_en) begin
            if (w_sum[ACC_W]) begin
                r_acc <= c_ACC_MAX;
                r_sat <= 1'b1;
            end else begin
                r_acc <= w_sum[ACC_W-1:0];
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sat = r_sat;

endmodule
`default_nettype wire

// File: rtl/conv_mac_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_mac_sequencer
//  Purpose  : Initiator-side sequencer for the shared 3-tap multiplier mux.
//             Accepts a 3-tap operand group, issues tap selects 01/10/11,
//             accumulates the returned products (saturating) and emits one
//             result per window (groups terminated by in_last).
//  Revision : 1.0  initial release
// ============================================================================
module conv_mac_sequencer
    import cnn_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PROD_W  = DEF_PROD_W,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MUL_LAT = 1            // legal range 1..3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a0,
    input  logic [DATA_W-1:0] in_a1,
    input  logic [DATA_W-1:0] in_a2,
    input  logic [DATA_W-1:0] in_k0,
    input  logic [DATA_W-1:0] in_k1,
    input  logic [DATA_W-1:0] in_k2,
    input  logic              in_last,
    output logic [1:0]        mux_sel,
    output logic [DATA_W-1:0] mux_a0,
    output logic [DATA_W-1:0] mux_a1,
    output logic [DATA_W-1:0] mux_a2,
    output logic [DATA_W-1:0] mux_k0,
    output logic [DATA_W-1:0] mux_k1,
    output logic [DATA_W-1:0] mux_k2,
    input  logic [PROD_W-1:0] mux_product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_sat
);

    // Final DRAIN count value: DRAIN lasts MUL_LAT cycles
    localparam logic [1:0] c_DRAIN_LAST = 2'(MUL_LAT - 1);
    localparam logic [1:0] c_ISSUE_LAST = 2'd2;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_cnt;
    logic [1:0]        w_cnt_next;
    logic [1:0]        r_mux_sel;
    logic [1:0]        w_sel_next;
    logic              r_last;
    logic [DATA_W-1:0] r_a0, r_a1, r_a2;
    logic [DATA_W-1:0] r_k0, r_k1, r_k2;
    logic [MUL_LAT-1:0] r_tag;
    logic              w_issue;
    logic              w_tag_out;
    logic              w_accept;
    logic              w_clear;

    assign w_issue  = (r_mux_sel != SEL_IDLE);
    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_clear  = (r_state == ST_OUT) && out_ready;

    // State register, issue-slot/drain counter and registered tap select
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= 2'd0;
            r_mux_sel <= SEL_IDLE;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_mux_sel <= w_sel_next;
        end
    end

    // Next-state, counter and next tap select (select is registered so the
    // multiplier sees a glitch-free value aligned with the state)
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_sel_next   = SEL_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_state_next = ST_ISSUE;
                    w_cnt_next   = 2'd0;
                end
            end
            ST_ISSUE: begin
                if (r_cnt == c_ISSUE_LAST) begin
                    w_state_next = ST_DRAIN;
                    w_cnt_next   = 2'd0;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            ST_DRAIN: begin
                if (r_cnt == c_DRAIN_LAST) begin
                    w_state_next = r_last ? ST_OUT : ST_IDLE;
                    w_cnt_next   = 2'd0;
                end else begin
                    w_cnt_next = r_cnt + 2'd1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = 2'd0;
            end
        endcase
        if (w_state_next == ST_ISSUE) begin
            w_sel_next = tap_sel(w_cnt_next);
        end
    end

    // Operand and last-flag capture on an accepted group; held for the group
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a0   <= '0;
            r_a1   <= '0;
            r_a2   <= '0;
            r_k0   <= '0;
            r_k1   <= '0;
            r_k2   <= '0;
            r_last <= 1'b0;
        end else if (w_accept) begin
            r_a0   <= in_a0;
            r_a1   <= in_a1;
            r_a2   <= in_a2;
            r_k0   <= in_k0;
            r_k1   <= in_k1;
            r_k2   <= in_k2;
            r_last <= in_last;
        end
    end

    // Issue-valid tag pipe: its output marks the cycle a product returns
    generate
        if (MUL_LAT == 1) begin : g_tag_single
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= w_issue;
                end
            end
        end else begin : g_tag_multi
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_tag <= '0;
                end else begin
                    r_tag <= {r_tag[MUL_LAT-2:0], w_issue};
                end
            end
        end
    endgenerate

    assign w_tag_out = r_tag[MUL_LAT-1];

    sat_acc #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_sat_acc (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_clear),
        .i_add_en (w_tag_out),
        .i_addend (mux_product),
        .o_acc    (out_sum),
        .o_sat    (out_sat)
    );

    // in_ready is forced low during reset; otherwise a decode of the state
    assign in_ready  = (r_state == ST_IDLE) && !rst;
    assign out_valid = (r_state == ST_OUT);
    assign mux_sel   = r_mux_sel;
    assign mux_a0    = r_a0;
    assign mux_a1    = r_a1;
    assign mux_a2    = r_a2;
    assign mux_k0    = r_k0;
    assign mux_k1    = r_k1;
    assign mux_k2    = r_k2;

endmodule
`default_nettype wire

// File: tb/tb_conv_mac_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_conv_mac_sequencer
//  Purpose  : Scoreboard bench for conv_mac_sequencer. Three instances:
//             0 = defaults, 1 = ACC_W 18, 2 = MUL_LAT 3. A bench-side
//             multiplier returns products and drives garbage otherwise.
//  Revision : 1.0  initial release
// ============================================================================
module tb_conv_mac_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic        in_last   [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        out_sat   [3];
    logic [7:0]  in_a      [3][3];
    logic [7:0]  in_k      [3][3];
    logic [7:0]  mux_a     [3][3];
    logic [7:0]  mux_k     [3][3];
    logic [1:0]  mux_sel   [3];
    logic [15:0] mux_product [3];
    logic [19:0] out_sum   [3];
    logic [19:0] sum0, sum2;
    logic [17:0] sum1;
    logic [15:0] pipe      [3][3];

    int total = 0;
    int bad   = 0;
    logic [20:0] q0[$], q1[$], q2[$];

    always #5 clk = ~clk;

    assign out_sum[0] = sum0;
    assign out_sum[1] = {2'b00, sum1};
    assign out_sum[2] = sum2;

    conv_mac_sequencer u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a0(in_a[0][0]), .in_a1(in_a[0][1]), .in_a2(in_a[0][2]),
        .in_k0(in_k[0][0]), .in_k1(in_k[0][1]), .in_k2(in_k[0][2]),
        .in_last(in_last[0]), .mux_sel(mux_sel[0]),
        .mux_a0(mux_a[0][0]), .mux_a1(mux_a[0][1]), .mux_a2(mux_a[0][2]),
        .mux_k0(mux_k[0][0]), .mux_k1(mux_k[0][1]), .mux_k2(mux_k[0][2]),
        .mux_product(mux_product[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_sum(sum0), .out_sat(out_sat[0])
    );

    conv_mac_sequencer #(.ACC_W(18)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a0(in_a[1][0]), .in_a1(in_a[1][1]), .in_a2(in_a[1][2]),
        .in_k0(in_k[1][0]), .in_k1(in_k[1][1]), .in_k2(in_k[1][2]),
        .in_last(in_last[1]), .mux_sel(mux_sel[1]),
        .mux_a0(mux_a[1][0]), .mux_a1(mux_a[1][1]), .mux_a2(mux_a[1][2]),
        .mux_k0(mux_k[1][0]), .mux_k1(mux_k[1][1]), .mux_k2(mux_k[1][2]),
        .mux_product(mux_product[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_sum(sum1), .out_sat(out_sat[1])
    );

    conv_mac_sequencer #(.MUL_LAT(3)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a0(in_a[2][0]), .in_a1(in_a[2][1]), .in_a2(in_a[2][2]),
        .in_k0(in_k[2][0]), .in_k1(in_k[2][1]), .in_k2(in_k[2][2]),
        .in_last(in_last[2]), .mux_sel(mux_sel[2]),
        .mux_a0(mux_a[2][0]), .mux_a1(mux_a[2][1]), .mux_a2(mux_a[2][2]),
        .mux_k0(mux_k[2][0]), .mux_k1(mux_k[2][1]), .mux_k2(mux_k[2][2]),
        .mux_product(mux_product[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_sum(sum2), .out_sat(out_sat[2])
    );

    // Multiplier: selected tap product, random garbage when mux_sel is idle
    function automatic logic [15:0] tap_prod(input logic [1:0] s,
                                             input logic [7:0] a0, a1, a2,
                                             input logic [7:0] k0, k1, k2,
                                             input logic [15:0] junk);
        case (s)
            2'b01:   return {8'd0, a0} * {8'd0, k0};
            2'b10:   return {8'd0, a1} * {8'd0, k1};
            2'b11:   return {8'd0, a2} * {8'd0, k2};
            default: return junk;
        endcase
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            pipe[d][2] <= pipe[d][1];
            pipe[d][1] <= pipe[d][0];
            pipe[d][0] <= tap_prod(mux_sel[d], mux_a[d][0], mux_a[d][1], mux_a[d][2],
                                   mux_k[d][0], mux_k[d][1], mux_k[d][2], 16'($urandom));
        end
    end

    assign mux_product[0] = pipe[0][0];
    assign mux_product[1] = pipe[1][0];
    assign mux_product[2] = pipe[2][2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int d, input logic [20:0] e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [20:0] pop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Present a group and hold it until accepted; returns at the negedge
    // of the first ISSUE cycle.
    task automatic send(input int d, input logic [7:0] a0, a1, a2,
                        input logic [7:0] k0, k1, k2, input logic last);
        int n = 0;
        @(negedge clk);
        in_valid[d] = 1'b1;
        in_a[d][0] = a0; in_a[d][1] = a1; in_a[d][2] = a2;
        in_k[d][0] = k0; in_k[d][1] = k1; in_k[d][2] = k2;
        in_last[d] = last;
        while (!in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("in_ready_timeout", 32'(in_ready[d]), 1);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_last[d]  = 1'b0;
    endtask

    task automatic wait_valid(input int d);
        int n = 0;
        while (!out_valid[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_wait", 32'(out_valid[d]), 1);
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin : mon
        logic [20:0] e;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                if (!rst && out_valid[d] && out_ready[d]) begin
                    if (qsize(d) == 0) begin
                        chk("unexpected_result_qdepth", 32'(qsize(d)), 1);
                    end else begin
                        e = pop(d);
                        chk($sformatf("out_sum[%0d]", d), 32'(out_sum[d]), 32'(e[19:0]));
                        chk($sformatf("out_sat[%0d]", d), 32'(out_sat[d]), 32'(e[20]));
                    end
                end
            end
        end
    end

    initial begin : stim
        int n;
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            in_valid[d] = 1'b0; in_last[d] = 1'b0; out_ready[d] = 1'b1;
            for (int t = 0; t < 3; t++) begin
                in_a[d][t] = 8'd0; in_k[d][t] = 8'd0;
            end
        end
        repeat (3) @(negedge clk);
        chk("in_ready_during_rst", 32'(in_ready[0]), 0);
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_in_ready",  32'(in_ready[d]), 1);
            chk("rst_mux_sel",   32'(mux_sel[d]), 0);
            chk("rst_out_valid", 32'(out_valid[d]), 0);
            chk("rst_out_sum",   32'(out_sum[d]), 0);
            chk("rst_out_sat",   32'(out_sat[d]), 0);
            chk("rst_mux_a0",    32'(mux_a[d][0]), 0);
        end

        // Basic group: 1*4 + 2*5 + 3*6 = 32, with cycle-exact timing
        push(0, {1'b0, 20'd32});
        send(0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 1'b1);
        chk("c1_mux_sel", 32'(mux_sel[0]), 1);
        @(negedge clk);
        chk("c2_mux_sel", 32'(mux_sel[0]), 2);
        @(negedge clk);
        chk("c3_mux_sel", 32'(mux_sel[0]), 3);
        @(negedge clk);
        chk("c4_mux_sel", 32'(mux_sel[0]), 0);
        chk("c4_out_valid", 32'(out_valid[0]), 0);
        @(negedge clk);
        chk("c5_out_valid", 32'(out_valid[0]), 1);
        @(negedge clk);
        chk("c6_in_ready", 32'(in_ready[0]), 1);
        chk("c6_out_valid", 32'(out_valid[0]), 0);

        // Three-group window of 255s: 9 * 65025 = 585225
        push(0, {1'b0, 20'd585225});
        send(0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send(0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send(0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        wait_valid(0);
        @(negedge clk);

        // Same window at ACC_W 18 saturates at 262143; next window starts clean
        push(1, {1'b1, 20'd262143});
        send(1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send(1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b0);
        send(1, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 1'b1);
        wait_valid(1);
        @(negedge clk);
        push(1, {1'b0, 20'd1});
        send(1, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 1'b1);
        wait_valid(1);
        @(negedge clk);

        // Backpressure: result 10+20+30 = 60 held for 4 cycles
        out_ready[0] = 1'b0;
        push(0, {1'b0, 20'd60});
        send(0, 8'd10, 8'd20, 8'd30, 8'd1, 8'd1, 8'd1, 1'b1);
        wait_valid(0);
        for (int i = 0; i < 4; i++) begin
            chk("bp_out_valid", 32'(out_valid[0]), 1);
            chk("bp_out_sum",   32'(out_sum[0]), 60);
            chk("bp_out_sat",   32'(out_sat[0]), 0);
            chk("bp_in_ready",  32'(in_ready[0]), 0);
            @(negedge clk);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready",  32'(in_ready[0]), 1);
        chk("bp_release_out_valid", 32'(out_valid[0]), 0);

        // MUL_LAT 3: 3 * (2*3) = 18, result in cycle 7
        push(2, {1'b0, 20'd18});
        send(2, 8'd2, 8'd2, 8'd2, 8'd3, 8'd3, 8'd3, 1'b1);
        repeat (5) @(negedge clk);
        chk("lat3_c6_out_valid", 32'(out_valid[2]), 0);
        @(negedge clk);
        chk("lat3_c7_out_valid", 32'(out_valid[2]), 1);
        chk("lat3_c7_out_sum",   32'(out_sum[2]), 18);
        @(negedge clk);

        // Reset in ISSUE cycle 2 drops the window
        send(0, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 8'd5, 1'b1);
        @(negedge clk);
        chk("prerst_mux_sel", 32'(mux_sel[0]), 2);
        rst = 1'b1;
        #1;
        chk("rst_pulse_in_ready", 32'(in_ready[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("postrst_mux_sel",   32'(mux_sel[0]), 0);
        chk("postrst_in_ready",  32'(in_ready[0]), 1);
        chk("postrst_out_valid", 32'(out_valid[0]), 0);
        chk("postrst_out_sum",   32'(out_sum[0]), 0);
        chk("postrst_out_sat",   32'(out_sat[0]), 0);
        chk("postrst_mux_a0",    32'(mux_a[0][0]), 0);
        repeat (6) @(negedge clk);
        chk("postrst_no_result", 32'(out_valid[0]), 0);
        chk("postrst_sum_idle",  32'(out_sum[0]), 0);
        push(0, {1'b0, 20'd3});
        send(0, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 1'b1);
        wait_valid(0);
        @(negedge clk);

        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("pending_results", 32'(q0.size() + q1.size() + q2.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
